// File: rtl/mips_divider.sv
// Sequential restoring divider for DIV/DIVU: one quotient bit per clock,
// start/busy/done handshake, LO = quotient, HI = remainder.
// Ports: clk, rst_n (async active-low), start, is_signed, dividend, divisor
//        -> busy, done (1-cycle pulse), quotient, remainder, div_by_zero.
module mips_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [4:0]         cnt_q, cnt_d;
   logic               neg_q_q, neg_q_d;
   logic               neg_r_q, neg_r_d;
   logic               zero_q, zero_d;
   logic [WIDTH-1:0]   raw_q, raw_d;
   logic [WIDTH-1:0]   dsr_q, dsr_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   res_q_q, res_q_d;
   logic [WIDTH-1:0]   res_r_q, res_r_d;
   logic               dbz_q, dbz_d;
   logic               done_q, done_d;

   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     trial;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x,
                                            input logic s);
      mag = (s & x[WIDTH-1]) ? (~x) + WIDTH'(1) : x;
   endfunction

   // Partial remainder stays below the divisor, so only WIDTH bits are kept;
   // the trial subtract runs at WIDTH+1 bits and its MSB is the borrow.
   assign shifted = {rem_q, quo_q[WIDTH-1]};
   assign trial   = shifted + {1'b1, ~dsr_q} + (WIDTH+1)'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      neg_q_d = neg_q_q;
      neg_r_d = neg_r_q;
      zero_d  = zero_q;
      raw_d   = raw_q;
      dsr_d   = dsr_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      res_q_d = res_q_q;
      res_r_d = res_r_q;
      dbz_d   = dbz_q;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               cnt_d   = '0;
               neg_q_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
               neg_r_d = is_signed & dividend[WIDTH-1];
               zero_d  = (divisor == '0);
               raw_d   = dividend;
               dsr_d   = mag(divisor, is_signed);
               quo_d   = mag(dividend, is_signed);
               rem_d   = '0;
            end
         end
         S_RUN: begin
            rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = S_FIX;
         end
         S_FIX: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            dbz_d   = zero_q;
            if (zero_q) begin
               res_q_d = '1;
               res_r_d = raw_q;
            end else begin
               res_q_d = neg_q_q ? (~quo_q) + WIDTH'(1) : quo_q;
               res_r_d = neg_r_q ? (~rem_q) + WIDTH'(1) : rem_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
         zero_q  <= 1'b0;
         raw_q   <= '0;
         dsr_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         res_q_q <= '0;
         res_r_q <= '0;
         dbz_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         neg_q_q <= neg_q_d;
         neg_r_q <= neg_r_d;
         zero_q  <= zero_d;
         raw_q   <= raw_d;
         dsr_q   <= dsr_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         res_q_q <= res_q_d;
         res_r_q <= res_r_d;
         dbz_q   <= dbz_d;
         done_q  <= done_d;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign quotient    = res_q_q;
   assign remainder   = res_r_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mips_divider.sv
// Directed bench for mips_divider: results, latency, handshake, reset abort.
// Expected values are hand-computed constants.
module tb_mips_divider;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        is_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   int asserts;
   int fails;

   mips_divider #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .is_signed   (is_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present operands, let the next rising edge (E0) accept them, then scramble.
   task automatic issue(input logic [31:0] a, input logic [31:0] b,
                        input logic s);
      start     = 1'b1;
      dividend  = a;
      divisor   = b;
      is_signed = s;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
   endtask

   // Called #1 after E0; returns #1 after the done edge (or the bound).
   task automatic wait_check(input string name, input logic [31:0] eq,
                             input logic [31:0] er, input logic ez,
                             input bit inject);
      int  n;
      int  nbusy;
      bit  seen;
      nbusy = busy ? 1 : 0;
      seen  = 1'b0;
      for (n = 1; n <= 40; n++) begin
         if (inject && n == 10) begin
            start     = 1'b1;
            dividend  = 32'd55;
            divisor   = 32'd5;
            is_signed = 1'b0;
         end
         if (inject && n == 11) start = 1'b0;
         @(posedge clk);
         #1;
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) nbusy++;
      end
      asserts++;
      if (!seen || n !== 33) begin
         $display("FAIL %s latency: got %0d want 33 (seen=%0b)", name, n, seen);
         fails++;
      end
      asserts++;
      if (nbusy !== 33) begin
         $display("FAIL %s busy_cycles: got %0d want 33", name, nbusy);
         fails++;
      end
      asserts++;
      if (busy !== 1'b0) begin
         $display("FAIL %s busy_at_done: got %b want 0", name, busy);
         fails++;
      end
      asserts++;
      if (quotient !== eq) begin
         $display("FAIL %s quotient: got %h want %h", name, quotient, eq);
         fails++;
      end
      asserts++;
      if (remainder !== er) begin
         $display("FAIL %s remainder: got %h want %h", name, remainder, er);
         fails++;
      end
      asserts++;
      if (div_by_zero !== ez) begin
         $display("FAIL %s div_by_zero: got %b want %b", name, div_by_zero, ez);
         fails++;
      end
   endtask

   // One cycle after done: pulse gone, results held.
   task automatic check_hold(input string name, input logic [31:0] eq,
                             input logic [31:0] er);
      @(posedge clk);
      #1;
      asserts++;
      if (done !== 1'b0 || quotient !== eq || remainder !== er) begin
         $display("FAIL %s hold: done=%b q=%h r=%h want 0 %h %h",
                  name, done, quotient, remainder, eq, er);
         fails++;
      end
   endtask

   task automatic run_div(input string name, input logic [31:0] a,
                          input logic [31:0] b, input logic s,
                          input logic [31:0] eq, input logic [31:0] er,
                          input logic ez);
      @(negedge clk);
      issue(a, b, s);
      wait_check(name, eq, er, ez, 1'b0);
      check_hold(name, eq, er);
   endtask

   task automatic test_reset;
      rst_n     = 1'b0;
      start     = 1'b0;
      is_signed = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (2) @(posedge clk);
      #1;
      asserts++;
      if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd0 ||
          remainder !== 32'd0 || div_by_zero !== 1'b0) begin
         $display("FAIL reset_state: busy=%b done=%b q=%h r=%h dbz=%b want all 0",
                  busy, done, quotient, remainder, div_by_zero);
         fails++;
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_unsigned;
      run_div("divu_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
      run_div("divu_max_1", 32'hFFFFFFFF, 32'd1, 1'b0,
              32'hFFFFFFFF, 32'd0, 1'b0);
   endtask

   task automatic test_signed;
      run_div("div_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1,
              32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
      run_div("div_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1,
              32'hFFFFFFFD, 32'd1, 1'b0);
      run_div("div_m7_m2", 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1,
              32'd3, 32'hFFFFFFFF, 1'b0);
      run_div("div_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1,
              32'h80000000, 32'd0, 1'b0);
   endtask

   task automatic test_div_zero;
      run_div("div_zero", 32'h12345678, 32'd0, 1'b1,
              32'hFFFFFFFF, 32'h12345678, 1'b1);
      run_div("clear_dbz", 32'd20, 32'd6, 1'b0, 32'd3, 32'd2, 1'b0);
   endtask

   task automatic test_ignore_start;
      @(negedge clk);
      issue(32'd1000, 32'd10, 1'b0);
      wait_check("ignore_start", 32'd100, 32'd0, 1'b0, 1'b1);
      check_hold("ignore_start", 32'd100, 32'd0);
      @(posedge clk);
      #1;
      asserts++;
      if (busy !== 1'b0) begin
         $display("FAIL ignore_start idle: busy got %b want 0", busy);
         fails++;
      end
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      issue(32'd50, 32'd6, 1'b0);
      wait_check("b2b_first", 32'd8, 32'd2, 1'b0, 1'b0);
      // Still inside the done cycle: request the next division right away.
      issue(32'hFFFFFF9C, 32'd7, 1'b1);
      asserts++;
      if (busy !== 1'b1) begin
         $display("FAIL b2b_accept: busy got %b want 1", busy);
         fails++;
      end
      wait_check("b2b_second", 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0);
      check_hold("b2b_second", 32'hFFFFFFF2, 32'hFFFFFFFE);
   endtask

   task automatic test_reset_abort;
      bit spurious;
      @(negedge clk);
      issue(32'd123456, 32'd7, 1'b0);
      repeat (15) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      asserts++;
      if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd0 ||
          remainder !== 32'd0 || div_by_zero !== 1'b0) begin
         $display("FAIL reset_abort: busy=%b done=%b q=%h r=%h want all 0",
                  busy, done, quotient, remainder);
         fails++;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n    = 1'b1;
      spurious = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done || busy) spurious = 1'b1;
      end
      asserts++;
      if (spurious !== 1'b0) begin
         $display("FAIL reset_no_done: spurious activity got 1 want 0");
         fails++;
      end
      run_div("after_reset", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);
   endtask

   initial begin
      asserts = 0;
      fails   = 0;
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_ignore_start();
      test_back_to_back();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures",
               asserts, fails);
      $finish;
   end

endmodule
